// File: rtl/alu_pipe_exe_unit_pkg.sv
// rtl/alu_pipe_exe_unit_pkg.sv - shared ALU widths, default tag widths and op encodings
package alu_pipe_exe_unit_pkg;

    localparam int DATA_LEN     = 32;
    localparam int ALU_OP_WIDTH = 4;
    localparam int RRF_TAG_LEN  = 6;
    localparam int ROB_TAG_LEN  = 6;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/alu_pipe_exe_unit_stage.sv
// rtl/alu_pipe_exe_unit_stage.sv - one result stage: valid bit with clear, payload with load enable
module alu_pipe_exe_unit_stage #(
    parameter int DATA_W    = 32,
    parameter int RRF_TAG_W = 6,
    parameter int ROB_TAG_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [DATA_W-1:0]    result,
    input  logic                 write_rrf,
    input  logic [RRF_TAG_W-1:0] rrf_tag,
    input  logic [ROB_TAG_W-1:0] rob_tag,
    output logic                 q_valid,
    output logic [DATA_W-1:0]    q_result,
    output logic                 q_write_rrf,
    output logic [RRF_TAG_W-1:0] q_rrf_tag,
    output logic [ROB_TAG_W-1:0] q_rob_tag
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
        end else if (clear) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid <= valid;
        end
    end

    // Payload is don't-care while invalid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            q_result    <= result;
            q_write_rrf <= write_rrf;
            q_rrf_tag   <= rrf_tag;
            q_rob_tag   <= rob_tag;
        end
    end

endmodule

// File: rtl/alu_pipe_exe_unit.sv
// rtl/alu_pipe_exe_unit.sv - pipelined ALU execute unit with writeback handshake and flush
// Optional perf counters enabled by defining ALU_PIPE_PERF_CNT_EN.
module alu_pipe_exe_unit
    import alu_pipe_exe_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_LEN,
    parameter int LATENCY   = 1,
    parameter int RRF_TAG_W = RRF_TAG_LEN,
    parameter int ROB_TAG_W = ROB_TAG_LEN
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    issue_i,
    output logic                    issue_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] alu_op_i,
    input  logic [DATA_W-1:0]       src1_i,
    input  logic [DATA_W-1:0]       src2_i,
    input  logic                    if_write_rrf_i,
    input  logic [RRF_TAG_W-1:0]    rrf_tag_i,
    input  logic [ROB_TAG_W-1:0]    rob_tag_i,
    input  logic                    kill_i,
    input  logic                    wb_ready_i,
    output logic [DATA_W-1:0]       result_o,
    output logic [RRF_TAG_W-1:0]    rrf_tag_o,
    output logic [ROB_TAG_W-1:0]    rob_tag_o,
    output logic                    wb_valid_o,
    output logic                    rob_we_o,
    output logic                    rrf_we_o
`ifdef ALU_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]             perf_issued_o,
    output logic [31:0]             perf_killed_o
`endif
);

    localparam int SH_W = $clog2(DATA_W);

    // Index 0 is the issue side (ALU output), index LATENCY the writeback stage.
    logic [LATENCY:0]     v;
    logic [LATENCY:0]     wr;
    logic [DATA_W-1:0]    res [0:LATENCY];
    logic [RRF_TAG_W-1:0] rrf [0:LATENCY];
    logic [ROB_TAG_W-1:0] rob [0:LATENCY];
    logic [LATENCY:1]     acc;
    logic [DATA_W-1:0]    alu_result;
    logic [SH_W-1:0]      shamt;

    assign shamt = src2_i[SH_W-1:0];

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(alu_op_i))
            ALU_ADD:  alu_result = src1_i + src2_i;
            ALU_SUB:  alu_result = src1_i - src2_i;
            ALU_AND:  alu_result = src1_i & src2_i;
            ALU_OR:   alu_result = src1_i | src2_i;
            ALU_XOR:  alu_result = src1_i ^ src2_i;
            ALU_SLL:  alu_result = src1_i << shamt;
            ALU_SRL:  alu_result = src1_i >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(src1_i) >>> shamt);
            ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(src1_i) < $signed(src2_i)};
            ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, src1_i < src2_i};
            default:  alu_result = '0;
        endcase
    end

    assign v[0]   = issue_i;
    assign wr[0]  = if_write_rrf_i;
    assign res[0] = alu_result;
    assign rrf[0] = rrf_tag_i;
    assign rob[0] = rob_tag_i;

    // A stage accepts when empty or when everything downstream moves; bubbles collapse.
    always_comb begin
        logic a;
        a   = wb_ready_i;
        acc = '0;
        for (int k = LATENCY; k >= 1; k--) begin
            a      = !v[k] | a;
            acc[k] = a;
        end
    end

    for (genvar k = 1; k <= LATENCY; k++) begin : g_stage
        alu_pipe_exe_unit_stage #(
            .DATA_W    (DATA_W),
            .RRF_TAG_W (RRF_TAG_W),
            .ROB_TAG_W (ROB_TAG_W)
        ) u_stage (
            .clk         (clk_i),
            .rst         (reset_i),
            .load        (acc[k]),
            .clear       (kill_i),
            .valid       (v[k-1]),
            .result      (res[k-1]),
            .write_rrf   (wr[k-1]),
            .rrf_tag     (rrf[k-1]),
            .rob_tag     (rob[k-1]),
            .q_valid     (v[k]),
            .q_result    (res[k]),
            .q_write_rrf (wr[k]),
            .q_rrf_tag   (rrf[k]),
            .q_rob_tag   (rob[k])
        );
    end

    assign issue_ready_o = acc[1];
    assign wb_valid_o    = v[LATENCY];
    assign result_o      = res[LATENCY];
    assign rrf_tag_o     = rrf[LATENCY];
    assign rob_tag_o     = rob[LATENCY];
    assign rob_we_o      = v[LATENCY] & wb_ready_i & !kill_i;
    assign rrf_we_o      = rob_we_o & wr[LATENCY];

`ifdef ALU_PIPE_PERF_CNT_EN
    logic [32:0] killed_sum;

    assign killed_sum = {1'b0, perf_killed_o} + 33'($countones(v[LATENCY:1]));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            perf_issued_o <= '0;
            perf_killed_o <= '0;
        end else begin
            if (issue_i && issue_ready_o && perf_issued_o != 32'hFFFF_FFFF) begin
                perf_issued_o <= perf_issued_o + 32'd1;
            end
            if (kill_i) begin
                perf_killed_o <= killed_sum[32] ? 32'hFFFF_FFFF : killed_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe_exe_unit.sv
// tb/tb_alu_pipe_exe_unit.sv - self-checking bench for alu_pipe_exe_unit with LATENCY=3
module tb_alu_pipe_exe_unit;
    import alu_pipe_exe_unit_pkg::*;

    localparam int L = 3;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        issue_i;
    logic        issue_ready_o;
    logic [3:0]  alu_op_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        if_write_rrf_i;
    logic [5:0]  rrf_tag_i;
    logic [5:0]  rob_tag_i;
    logic        kill_i;
    logic        wb_ready_i;
    logic [31:0] result_o;
    logic [5:0]  rrf_tag_o;
    logic [5:0]  rob_tag_o;
    logic        wb_valid_o;
    logic        rob_we_o;
    logic        rrf_we_o;

    alu_pipe_exe_unit #(
        .DATA_W    (32),
        .LATENCY   (L),
        .RRF_TAG_W (6),
        .ROB_TAG_W (6)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .issue_i        (issue_i),
        .issue_ready_o  (issue_ready_o),
        .alu_op_i       (alu_op_i),
        .src1_i         (src1_i),
        .src2_i         (src2_i),
        .if_write_rrf_i (if_write_rrf_i),
        .rrf_tag_i      (rrf_tag_i),
        .rob_tag_i      (rob_tag_i),
        .kill_i         (kill_i),
        .wb_ready_i     (wb_ready_i),
        .result_o       (result_o),
        .rrf_tag_o      (rrf_tag_o),
        .rob_tag_o      (rob_tag_o),
        .wb_valid_o     (wb_valid_o),
        .rob_we_o       (rob_we_o),
        .rrf_we_o       (rrf_we_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic [5:0]  rrf;
        logic [5:0]  rob;
        int          acc;
    } op_t;

    op_t q[$];
    int  cyc = 0;
    int  last_fire = -100;
    int  vectors = 0;
    int  miscompares = 0;

    function automatic logic [31:0] ref_alu(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        int signed       sa = a;
        int signed       sb = b;
        int              sh = int'(b % 32);
        longint unsigned t;
        case (op)
            ALU_ADD:  t = ua + ub;
            ALU_SUB:  t = ua + 64'h1_0000_0000 - ub;
            ALU_AND:  t = ua & ub;
            ALU_OR:   t = ua | ub;
            ALU_XOR:  t = ua ^ ub;
            ALU_SLL:  t = ua * (64'd1 << sh);
            ALU_SRL:  t = ua / (64'd1 << sh);
            ALU_SRA:  t = longint'(sa >>> sh);
            ALU_SLT:  t = (sa < sb) ? 1 : 0;
            ALU_SLTU: t = (ua < ub) ? 1 : 0;
            default:  t = 0;
        endcase
        return t[31:0];
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit iss, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                         bit wr, logic [5:0] rrf, logic [5:0] rob, bit kl, bit rdy);
        issue_i        = iss;
        alu_op_i       = op;
        src1_i         = a;
        src2_i         = b;
        if_write_rrf_i = wr;
        rrf_tag_i      = rrf;
        rob_tag_i      = rob;
        kill_i         = kl;
        wb_ready_i     = rdy;
    endtask

    task automatic idle(bit rdy);
        drive(0, 4'd0, 32'd0, 32'd0, 0, 6'd0, 6'd0, 0, rdy);
    endtask

    // One clock cycle: compare DUT against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit exp_valid;
        bit exp_ready;
        bit fire;
        int pt;
        op_t n;
        @(negedge clk);
        exp_valid = 1'b0;
        if (q.size() > 0) begin
            pt = q[0].acc + L;
            if (last_fire + 1 > pt) pt = last_fire + 1;
            exp_valid = (cyc >= pt);
        end
        exp_ready = (q.size() < L) || wb_ready_i;
        fire      = exp_valid && wb_ready_i && !kill_i;
        chk("issue_ready", issue_ready_o, exp_ready);
        chk("wb_valid", wb_valid_o, exp_valid);
        chk("rob_we", rob_we_o, fire);
        if (exp_valid) begin
            chk("rrf_we", rrf_we_o, fire && q[0].wr);
            chk("result", result_o, q[0].data);
            chk("rrf_tag", rrf_tag_o, q[0].rrf);
            chk("rob_tag", rob_tag_o, q[0].rob);
        end else begin
            chk("rrf_we_idle", rrf_we_o, 1'b0);
        end
        @(posedge clk);
        if (kill_i) begin
            q.delete();
        end else begin
            if (fire) begin
                void'(q.pop_front());
                last_fire = cyc;
            end
            if (issue_i && exp_ready) begin
                n.data = ref_alu(alu_op_i, src1_i, src2_i);
                n.wr   = if_write_rrf_i;
                n.rrf  = rrf_tag_i;
                n.rob  = rob_tag_i;
                n.acc  = cyc;
                q.push_back(n);
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        idle(1);
        repeat (2) @(posedge clk);
        #2;
        chk("reset_wb_valid", wb_valid_o, 1'b0);
        chk("reset_rob_we", rob_we_o, 1'b0);
        chk("reset_rrf_we", rrf_we_o, 1'b0);
        reset_i = 1'b0;
        #1;
        chk("reset_issue_ready", issue_ready_o, 1'b1);

        // ADD 5+7 appears exactly LATENCY cycles later
        drive(1, ALU_ADD, 32'd5, 32'd7, 1, 6'd9, 6'd2, 0, 1);
        cycle();
        idle(1);
        cycle();
        cycle();
        #2;
        chk("lat3_valid", wb_valid_o, 1'b1);
        chk("lat3_result", result_o, 32'd12);
        chk("lat3_rrf_we", rrf_we_o, 1'b1);
        chk("lat3_rrf_tag", rrf_tag_o, 6'd9);
        cycle();

        // back-to-back issue at full throughput
        for (int i = 1; i <= 3; i++) begin
            drive(1, ALU_ADD, 32'(i), 32'(i), 1, 6'(i), 6'(i), 0, 1);
            cycle();
        end
        idle(1);
        repeat (4) cycle();

        // stall: pipe fills with LATENCY ops, fourth is refused
        for (int i = 0; i < 4; i++) begin
            drive(1, ALU_XOR, 32'hA5A5_0000 + 32'(i), 32'h0F0F_0F0F, 1, 6'(10 + i), 6'(20 + i), 0, 0);
            if (i == 3) begin
                #2;
                chk("full_issue_ready", issue_ready_o, 1'b0);
            end
            cycle();
        end
        idle(0);
        repeat (3) cycle();
        idle(1);
        repeat (5) cycle();

        // kill with two ops in flight plus a simultaneous issue
        drive(1, ALU_SUB, 32'd100, 32'd1, 1, 6'd1, 6'd1, 0, 1);
        cycle();
        drive(1, ALU_SUB, 32'd200, 32'd2, 1, 6'd2, 6'd2, 0, 1);
        cycle();
        drive(1, ALU_SUB, 32'd300, 32'd3, 1, 6'd3, 6'd3, 1, 1);
        cycle();
        idle(1);
        #2;
        chk("post_kill_ready", issue_ready_o, 1'b1);
        repeat (5) cycle();

        // op that does not write a rename register
        drive(1, ALU_ADD, 32'h1000, 32'h24, 0, 6'd5, 6'd7, 0, 1);
        cycle();
        idle(1);
        cycle();
        cycle();
        #2;
        chk("nowr_rob_we", rob_we_o, 1'b1);
        chk("nowr_rrf_we", rrf_we_o, 1'b0);
        cycle();

        // asynchronous reset with ops in flight and one stalled at the output
        drive(1, ALU_OR, 32'h11, 32'h22, 1, 6'd3, 6'd4, 0, 0);
        cycle();
        drive(1, ALU_OR, 32'h33, 32'h44, 1, 6'd5, 6'd6, 0, 0);
        cycle();
        idle(0);
        repeat (3) cycle();
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_valid", wb_valid_o, 1'b0);
        chk("async_rst_rob_we", rob_we_o, 1'b0);
        q.delete();
        idle(1);
        @(posedge clk);
        #2;
        reset_i = 1'b0;
        #1;
        chk("rst_release_ready", issue_ready_o, 1'b1);

        // wrap-around after reset, also checks latency from a clean pipe
        drive(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1, 6'd8, 6'd9, 0, 1);
        cycle();
        idle(1);
        cycle();
        cycle();
        #2;
        chk("wrap_valid", wb_valid_o, 1'b1);
        chk("wrap_result", result_o, 32'd0);
        cycle();

        // randomized traffic with backpressure and occasional kills
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 9)), a, b,
                  $urandom_range(0, 1) == 1, 6'($urandom()), 6'($urandom()),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
            cycle();
        end
        idle(1);
        repeat (8) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
